// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: access encodings,
// FSM state constants and write-back mux select codes.
package pipe_mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [2:0] WB_SEL_PC4  = 3'd1;
  localparam logic [2:0] WB_SEL_DMEM = 3'd4;
  localparam logic [2:0] WB_SEL_ALU  = 3'd5;

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op != 3'd4);
  endfunction

endpackage

// File: rtl/pipe_mem_align.sv
// Combinational byte-lane logic: store data/enable formatting, alignment
// check for the incoming request, and extraction of returned load data.
module pipe_mem_align
  import pipe_mem_pkg::*;
(
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_rt,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic        req_misaligned,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_wdata      = req_rt;
    req_be         = 4'b1111;
    req_misaligned = 1'b0;
    case (mem_op_e'(req_op))
      OP_SB: begin
        req_wdata = {4{req_rt[7:0]}};
        req_be    = 4'b0001 << req_addr_lo;
      end
      OP_SH: begin
        req_wdata      = {2{req_rt[15:0]}};
        req_be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        req_misaligned = req_addr_lo[0];
      end
      OP_LH, OP_LHU: req_misaligned = req_addr_lo[0];
      OP_LW, OP_SW:  req_misaligned = |req_addr_lo;
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (mem_op_e'(ld_op))
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/pipe_mem.sv
// MEM stage of the 5-stage pipeline: issues data-memory accesses over req/ack,
// stalls upstream while one is outstanding, and owns the MEM/WB register.
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_en,
  input  logic [2:0]        ex_mem_op,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_rt_data,
  input  logic [31:0]       ex_rs_data,
  input  logic [31:0]       ex_pc4,
  input  logic [4:0]        ex_rf_waddr,
  input  logic              ex_rf_wena,
  input  logic [2:0]        ex_rf_mux_sel,
  output logic              mem_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       alu_out,
  output logic [31:0]       dmem_out,
  output logic [31:0]       pc4,
  output logic [31:0]       rs_data_out,
  output logic [4:0]        rf_waddr,
  output logic              rf_wena,
  output logic [2:0]        rf_mux_sel,
  output logic              addr_err,
  output logic              timeout_err
);

  // Down-counter preloaded on entry; terminal count 0 is the last allowed cycle.
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;
  localparam bit TMO_EN = (MAX_WAIT > 0);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       acc_alu_q, acc_alu_d, acc_rs_q, acc_rs_d, acc_pc4_q, acc_pc4_d;
  logic [4:0]        acc_waddr_q, acc_waddr_d;
  logic              acc_wena_q, acc_wena_d;
  logic [2:0]        acc_sel_q, acc_sel_d;
  logic [31:0]       alu_out_q, alu_out_d, dmem_out_q, dmem_out_d;
  logic [31:0]       pc4_q, pc4_d, rs_data_q, rs_data_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic              rf_wena_q, rf_wena_d;
  logic [2:0]        rf_mux_sel_q, rf_mux_sel_d;
  logic              addr_err_q, addr_err_d, timeout_err_q, timeout_err_d;
  logic              stall_c;

  logic [31:0] req_wdata, ld_data;
  logic [3:0]  req_be;
  logic        req_misaligned;

  pipe_mem_align u_align (
    .req_op         (ex_mem_op),
    .req_addr_lo    (ex_alu_out[1:0]),
    .req_rt         (ex_rt_data),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .req_misaligned (req_misaligned),
    .ld_op          (op_q),
    .ld_addr_lo     (addr_lo_q),
    .ld_rdata       (dm_rdata),
    .ld_data        (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_be_d       = dm_be_q;
    dm_wdata_d    = dm_wdata_q;
    op_d          = op_q;
    addr_lo_d     = addr_lo_q;
    acc_alu_d     = acc_alu_q;
    acc_rs_d      = acc_rs_q;
    acc_pc4_d     = acc_pc4_q;
    acc_waddr_d   = acc_waddr_q;
    acc_wena_d    = acc_wena_q;
    acc_sel_d     = acc_sel_q;
    alu_out_d     = alu_out_q;
    dmem_out_d    = dmem_out_q;
    pc4_d         = pc4_q;
    rs_data_d     = rs_data_q;
    rf_waddr_d    = rf_waddr_q;
    rf_wena_d     = rf_wena_q;
    rf_mux_sel_d  = rf_mux_sel_q;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    stall_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid && ex_mem_en) begin
          rf_wena_d = 1'b0;
          if (req_misaligned) begin
            addr_err_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            stall_c     = 1'b1;
            wait_d      = WAIT_LOAD;
            dm_req_d    = 1'b1;
            dm_we_d     = is_store(ex_mem_op);
            dm_addr_d   = {ex_alu_out[ADDR_W-1:2], 2'b00};
            dm_be_d     = req_be;
            dm_wdata_d  = req_wdata;
            op_d        = ex_mem_op;
            addr_lo_d   = ex_alu_out[1:0];
            acc_alu_d   = ex_alu_out;
            acc_rs_d    = ex_rs_data;
            acc_pc4_d   = ex_pc4;
            acc_waddr_d = ex_rf_waddr;
            acc_wena_d  = ex_rf_wena;
            acc_sel_d   = ex_rf_mux_sel;
          end
        end else if (ex_valid) begin
          alu_out_d    = ex_alu_out;
          dmem_out_d   = 32'd0;
          pc4_d        = ex_pc4;
          rs_data_d    = ex_rs_data;
          rf_waddr_d   = ex_rf_waddr;
          rf_wena_d    = ex_rf_wena;
          rf_mux_sel_d = ex_rf_mux_sel;
        end else begin
          rf_wena_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (dm_ack) begin
          state_d      = ST_IDLE;
          dm_req_d     = 1'b0;
          alu_out_d    = acc_alu_q;
          dmem_out_d   = is_store(op_q) ? 32'd0 : ld_data;
          pc4_d        = acc_pc4_q;
          rs_data_d    = acc_rs_q;
          rf_waddr_d   = acc_waddr_q;
          rf_wena_d    = acc_wena_q;
          rf_mux_sel_d = acc_sel_q;
        end else if (TMO_EN && (wait_q == '0)) begin
          state_d       = ST_IDLE;
          dm_req_d      = 1'b0;
          rf_wena_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          if (wait_q != '0) wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_be_q       <= 4'd0;
      dm_wdata_q    <= 32'd0;
      op_q          <= 3'd0;
      addr_lo_q     <= 2'd0;
      acc_alu_q     <= 32'd0;
      acc_rs_q      <= 32'd0;
      acc_pc4_q     <= 32'd0;
      acc_waddr_q   <= 5'd0;
      acc_wena_q    <= 1'b0;
      acc_sel_q     <= 3'd0;
      alu_out_q     <= 32'd0;
      dmem_out_q    <= 32'd0;
      pc4_q         <= 32'd0;
      rs_data_q     <= 32'd0;
      rf_waddr_q    <= 5'd0;
      rf_wena_q     <= 1'b0;
      rf_mux_sel_q  <= 3'd0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_be_q       <= dm_be_d;
      dm_wdata_q    <= dm_wdata_d;
      op_q          <= op_d;
      addr_lo_q     <= addr_lo_d;
      acc_alu_q     <= acc_alu_d;
      acc_rs_q      <= acc_rs_d;
      acc_pc4_q     <= acc_pc4_d;
      acc_waddr_q   <= acc_waddr_d;
      acc_wena_q    <= acc_wena_d;
      acc_sel_q     <= acc_sel_d;
      alu_out_q     <= alu_out_d;
      dmem_out_q    <= dmem_out_d;
      pc4_q         <= pc4_d;
      rs_data_q     <= rs_data_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wena_q     <= rf_wena_d;
      rf_mux_sel_q  <= rf_mux_sel_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Stall is combinational; forced low while reset is held so upstream is not frozen.
  assign mem_stall   = stall_c & ~rst;
  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_be       = dm_be_q;
  assign dm_wdata    = dm_wdata_q;
  assign alu_out     = alu_out_q;
  assign dmem_out    = dmem_out_q;
  assign pc4         = pc4_q;
  assign rs_data_out = rs_data_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wena     = rf_wena_q;
  assign rf_mux_sel  = rf_mux_sel_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipe_mem.sv
// Self-checking bench for pipe_mem: write-back results are queued when an
// instruction is driven and popped when the stage delivers them.
module tb_pipe_mem;
  import pipe_mem_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_en, ex_rf_wena;
  logic [2:0]  ex_mem_op, ex_rf_mux_sel;
  logic [31:0] ex_alu_out, ex_rt_data, ex_rs_data, ex_pc4;
  logic [4:0]  ex_rf_waddr;
  logic        mem_stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic [31:0] alu_out, dmem_out, pc4, rs_data_out;
  logic [4:0]  rf_waddr;
  logic        rf_wena, addr_err, timeout_err;
  logic [2:0]  rf_mux_sel;

  always #5 clk = ~clk;

  pipe_mem #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_en(ex_mem_en), .ex_mem_op(ex_mem_op),
    .ex_alu_out(ex_alu_out), .ex_rt_data(ex_rt_data), .ex_rs_data(ex_rs_data),
    .ex_pc4(ex_pc4), .ex_rf_waddr(ex_rf_waddr), .ex_rf_wena(ex_rf_wena),
    .ex_rf_mux_sel(ex_rf_mux_sel), .mem_stall(mem_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .alu_out(alu_out), .dmem_out(dmem_out), .pc4(pc4), .rs_data_out(rs_data_out),
    .rf_waddr(rf_waddr), .rf_wena(rf_wena), .rf_mux_sel(rf_mux_sel),
    .addr_err(addr_err), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [4:0]  waddr;
    logic        wena;
    logic [2:0]  sel;
  } wb_t;

  wb_t wb_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * a);
    h = w >> (16 * a[1]);
    case (op)
      OP_LB:   return 32'($signed(b[7:0]));
      OP_LBU:  return b & 32'h0000_00FF;
      OP_LH:   return 32'($signed(h[15:0]));
      OP_LHU:  return h & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] op, input logic [1:0] a);
    if (op == OP_SB) return 4'(1 << a);
    if (op == OP_SH) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] op, input logic [31:0] rt);
    if (op == OP_SB) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    if (op == OP_SH) return {rt[15:0], rt[15:0]};
    return rt;
  endfunction

  // Drives one aligned memory op from #1 after an edge in IDLE; ack after 'waits'
  // wait cycles. Returns at #1 after the edge where write-back lands.
  task automatic drive_mem(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rdata,
                           input int waits, output int stall_n,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_be, output logic o_we,
                           output logic o_req_first, output logic o_req_after);
    wb_t e;
    logic st;
    st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    ex_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_op = op;
    ex_alu_out = addr; ex_rt_data = rt; ex_rs_data = addr ^ 32'h5A5A_0000;
    ex_pc4 = 32'h0040_0000 + addr; ex_rf_waddr = 5'd9; ex_rf_wena = ~st;
    ex_rf_mux_sel = st ? WB_SEL_ALU : WB_SEL_DMEM;
    dm_ack = 1'b0;
    e.alu = addr; e.dmem = st ? 32'd0 : ld_model(op, addr[1:0], rdata);
    e.pc4 = ex_pc4; e.rs = ex_rs_data; e.waddr = 5'd9; e.wena = ~st;
    e.sel = ex_rf_mux_sel;
    wb_q.push_back(e);
    #1 stall_n = int'(mem_stall);
    @(posedge clk); #1;
    o_req_first = dm_req; o_addr = dm_addr; o_wdata = dm_wdata; o_be = dm_be; o_we = dm_we;
    for (int w = 0; w <= waits; w++) begin
      dm_ack   = (w == waits);
      dm_rdata = (w == waits) ? rdata : 32'hDEAD_BEEF;
      #1 stall_n += int'(mem_stall);
      if (w < waits) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    dm_ack = 1'b0; ex_valid = 1'b0; ex_mem_en = 1'b0;
    o_req_after = dm_req;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (dm_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dm_req); else n_pass++;
    n_total++; if (alu_out !== 32'd0) $display("FAIL rst_alu: got %h want 0", alu_out); else n_pass++;
    n_total++; if (rf_wena !== 1'b0) $display("FAIL rst_wena: got %b want 0", rf_wena); else n_pass++;
    n_total++; if ({dm_addr, dm_wdata, dm_be, dm_we} !== '0)
      $display("FAIL rst_bus: got %h/%h/%b/%b want 0", dm_addr, dm_wdata, dm_be, dm_we); else n_pass++;
    n_total++; if ({addr_err, timeout_err, mem_stall} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000", {addr_err, timeout_err, mem_stall}); else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [31:0] vals [2];
    wb_t e;
    vals[0] = 32'h1234_5678; vals[1] = 32'hFEDC_0001;
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'b1; ex_mem_en = 1'b0; ex_mem_op = OP_LW; ex_alu_out = vals[i];
      ex_rs_data = 32'h0000_0100 + 32'(i); ex_pc4 = 32'h0040_0010 + 32'(4 * i);
      ex_rf_waddr = 5'(3 + i); ex_rf_wena = 1'b1;
      ex_rf_mux_sel = (i == 0) ? WB_SEL_ALU : WB_SEL_PC4;
      dm_ack = (i == 1);  // a stray ack in IDLE must not matter
      e.alu = vals[i]; e.dmem = 32'd0; e.pc4 = ex_pc4; e.rs = ex_rs_data;
      e.waddr = ex_rf_waddr; e.wena = 1'b1; e.sel = ex_rf_mux_sel;
      wb_q.push_back(e);
      #1;
      n_total++; if (mem_stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", mem_stall); else n_pass++;
      @(posedge clk); #1;
      ex_valid = 1'b0; dm_ack = 1'b0;
      e = wb_q.pop_front();
      n_total++; if (alu_out !== e.alu) $display("FAIL alu_out: got %h want %h", alu_out, e.alu); else n_pass++;
      n_total++; if ({rf_wena, rf_waddr, rf_mux_sel} !== {e.wena, e.waddr, e.sel})
        $display("FAIL alu_ctl: got %b/%0d/%0d want %b/%0d/%0d", rf_wena, rf_waddr, rf_mux_sel,
                 e.wena, e.waddr, e.sel); else n_pass++;
      n_total++; if ({pc4, rs_data_out, dmem_out} !== {e.pc4, e.rs, e.dmem})
        $display("FAIL alu_pass: got %h/%h/%h want %h/%h/%h", pc4, rs_data_out, dmem_out,
                 e.pc4, e.rs, e.dmem); else n_pass++;
      n_total++; if (dm_req !== 1'b0) $display("FAIL alu_noreq: got %b want 0", dm_req); else n_pass++;
    end
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4];
    logic [31:0] adr [4];
    int          wts [4];
    int stall_n; logic [31:0] oa, ow; logic [3:0] ob; logic owe, rq0, rq1;
    wb_t e;
    ops[0] = OP_LB;  adr[0] = 32'h103; wts[0] = 2;
    ops[1] = OP_LBU; adr[1] = 32'h103; wts[1] = 2;
    ops[2] = OP_LH;  adr[2] = 32'h102; wts[2] = 0;
    ops[3] = OP_LHU; adr[3] = 32'h100; wts[3] = 1;
    for (int i = 0; i < 4; i++) begin
      drive_mem(ops[i], adr[i], 32'd0, 32'h80FF_7F01, wts[i], stall_n, oa, ow, ob, owe, rq0, rq1);
      e = wb_q.pop_front();
      n_total++; if (stall_n != 1 + wts[i])
        $display("FAIL ld%0d_stall_cycles: got %0d want %0d", i, stall_n, 1 + wts[i]); else n_pass++;
      n_total++; if ({rq0, rq1, owe} !== 3'b100)
        $display("FAIL ld%0d_req: got req %b/%b we %b want 1/0 we 0", i, rq0, rq1, owe); else n_pass++;
      n_total++; if (oa !== (adr[i] & ~32'd3))
        $display("FAIL ld%0d_addr: got %h want %h", i, oa, adr[i] & ~32'd3); else n_pass++;
      n_total++; if (dmem_out !== e.dmem)
        $display("FAIL ld%0d_data: got %h want %h", i, dmem_out, e.dmem); else n_pass++;
      n_total++; if ({rf_wena, alu_out, pc4} !== {e.wena, e.alu, e.pc4})
        $display("FAIL ld%0d_wb: got %b/%h/%h want %b/%h/%h", i, rf_wena, alu_out, pc4,
                 e.wena, e.alu, e.pc4); else n_pass++;
    end
  endtask

  task automatic test_stores();
    logic [2:0]  ops [3];
    logic [31:0] adr [3], rts [3];
    int stall_n; logic [31:0] oa, ow; logic [3:0] ob; logic owe, rq0, rq1;
    wb_t e;
    ops[0] = OP_SH; adr[0] = 32'h202; rts[0] = 32'hAAAA_1234;
    ops[1] = OP_SB; adr[1] = 32'h201; rts[1] = 32'h1122_33CD;
    ops[2] = OP_SW; adr[2] = 32'h204; rts[2] = 32'hCAFE_BABE;
    for (int i = 0; i < 3; i++) begin
      drive_mem(ops[i], adr[i], rts[i], 32'h7777_7777, i, stall_n, oa, ow, ob, owe, rq0, rq1);
      e = wb_q.pop_front();
      n_total++; if ({owe, rq0, rq1} !== 3'b110)
        $display("FAIL st%0d_we_req: got we %b req %b/%b want 1 1/0", i, owe, rq0, rq1); else n_pass++;
      n_total++; if (ob !== be_model(ops[i], adr[i][1:0]))
        $display("FAIL st%0d_be: got %b want %b", i, ob, be_model(ops[i], adr[i][1:0])); else n_pass++;
      n_total++; if (ow !== wd_model(ops[i], rts[i]))
        $display("FAIL st%0d_wdata: got %h want %h", i, ow, wd_model(ops[i], rts[i])); else n_pass++;
      n_total++; if ({rf_wena, dmem_out, alu_out} !== {e.wena, e.dmem, e.alu})
        $display("FAIL st%0d_wb: got %b/%h/%h want %b/%h/%h", i, rf_wena, dmem_out, alu_out,
                 e.wena, e.dmem, e.alu); else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops [2];
    logic [31:0] adr [2];
    ops[0] = OP_LW; adr[0] = 32'h301;
    ops[1] = OP_SH; adr[1] = 32'h305;
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_op = ops[i]; ex_alu_out = adr[i];
      ex_rf_wena = 1'b1; ex_rt_data = 32'h1;
      #1;
      n_total++; if (mem_stall !== 1'b0) $display("FAIL mis%0d_stall: got %b want 0", i, mem_stall); else n_pass++;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_en = 1'b0;
      n_total++; if ({addr_err, dm_req, rf_wena} !== 3'b100)
        $display("FAIL mis%0d_flags: got err %b req %b wena %b want 1 0 0", i, addr_err, dm_req, rf_wena);
      else n_pass++;
      @(posedge clk); #1;
      n_total++; if (addr_err !== 1'b0) $display("FAIL mis%0d_pulse: got %b want 0", i, addr_err); else n_pass++;
    end
  endtask

  task automatic test_timeout_back_to_back();
    int n = 0;
    bit seen = 1'b0;
    int stall_n; logic [31:0] oa, ow; logic [3:0] ob; logic owe, rq0, rq1;
    wb_t e;
    ex_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_op = OP_LH; ex_alu_out = 32'h110;
    ex_rf_wena = 1'b1; dm_ack = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (timeout_err) seen = 1'b1;
      else if (dm_req) begin
        n++;
        #1;
        if (n == MAX_WAIT - 1) begin
          n_total++; if (mem_stall !== 1'b1) $display("FAIL tmo_stall_pre: got %b want 1", mem_stall); else n_pass++;
        end
        if (n == MAX_WAIT) begin
          n_total++; if (mem_stall !== 1'b0) $display("FAIL tmo_stall_last: got %b want 0", mem_stall); else n_pass++;
        end
      end
    end
    n_total++; if (!seen) $display("FAIL tmo_seen: got no timeout_err within 40 cycles want pulse"); else n_pass++;
    n_total++; if (n != MAX_WAIT) $display("FAIL tmo_wait_cycles: got %0d want %0d", n, MAX_WAIT); else n_pass++;
    n_total++; if ({dm_req, rf_wena} !== 2'b00)
      $display("FAIL tmo_abandon: got req %b wena %b want 0 0", dm_req, rf_wena); else n_pass++;
    drive_mem(OP_LW, 32'h120, 32'd0, 32'hCAFE_F00D, 0, stall_n, oa, ow, ob, owe, rq0, rq1);
    e = wb_q.pop_front();
    n_total++; if ({rq0, rq1, stall_n} !== {1'b1, 1'b0, 32'd1})
      $display("FAIL b2b_req: got req %b/%b stalls %0d want 1/0 1", rq0, rq1, stall_n); else n_pass++;
    n_total++; if ({dmem_out, rf_wena, timeout_err} !== {e.dmem, e.wena, 1'b0})
      $display("FAIL b2b_wb: got %h/%b tmo %b want %h/%b tmo 0", dmem_out, rf_wena, timeout_err,
               e.dmem, e.wena); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int stall_n; logic [31:0] oa, ow; logic [3:0] ob; logic owe, rq0, rq1;
    wb_t e;
    ex_valid = 1'b1; ex_mem_en = 1'b1; ex_mem_op = OP_LW; ex_alu_out = 32'h140;
    ex_rf_wena = 1'b1; dm_ack = 1'b0;
    @(posedge clk); #1;
    n_total++; if (dm_req !== 1'b1) $display("FAIL rmid_req_before: got %b want 1", dm_req); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({dm_req, mem_stall, rf_wena, timeout_err} !== 4'b0000)
      $display("FAIL rmid_ctl: got req %b stall %b wena %b tmo %b want 0", dm_req, mem_stall,
               rf_wena, timeout_err); else n_pass++;
    n_total++; if ({alu_out, dm_addr, dmem_out} !== '0)
      $display("FAIL rmid_data: got %h/%h/%h want 0", alu_out, dm_addr, dmem_out); else n_pass++;
    ex_valid = 1'b0; ex_mem_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (dm_req !== 1'b0) $display("FAIL rmid_idle: got req %b want 0", dm_req); else n_pass++;
    drive_mem(OP_LW, 32'h144, 32'd0, 32'h0BAD_C0DE, 1, stall_n, oa, ow, ob, owe, rq0, rq1);
    e = wb_q.pop_front();
    n_total++; if ({dmem_out, rf_wena, alu_out} !== {e.dmem, e.wena, e.alu})
      $display("FAIL rmid_after: got %h/%b/%h want %h/%b/%h", dmem_out, rf_wena, alu_out,
               e.dmem, e.wena, e.alu); else n_pass++;
  endtask

  initial begin
    ex_valid = 1'b0; ex_mem_en = 1'b0; ex_mem_op = 3'd0; ex_alu_out = '0; ex_rt_data = '0;
    ex_rs_data = '0; ex_pc4 = '0; ex_rf_waddr = '0; ex_rf_wena = 1'b0; ex_rf_mux_sel = '0;
    dm_ack = 1'b0; dm_rdata = '0;
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout_back_to_back();
    test_reset_mid_access();
    n_total++; if (wb_q.size() != 0) $display("FAIL sb_drain: got %0d left want 0", wb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
